uart_cmd_ctrl: RTL and testbench
================================

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, UART bit rate.
REQ-003 SHALL have parameter NUM_SW, default 5, range 1..10, number of virtual switches.
REQ-004 SHALL have parameter PARITY, default 0, where 0 = none, 1 = even, 2 = odd.
REQ-005 SHALL have port clk, input, 1 bit, the single system clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1 bit; reset is asynchronous and active-low.
REQ-007 SHALL have port uart_rx, input, 1 bit, serial line, idle high, asynchronous to clk.
REQ-008 SHALL have port sw_out, output, NUM_SW bits, virtual switch levels.
REQ-009 SHALL have ports btn_r, btn_l, btn_u, btn_d and btn_s, outputs, 1 bit each, single-cycle command pulses.
REQ-010 SHALL have port rx_data, output, 8 bits, last accepted byte.
REQ-011 SHALL have port rx_valid, output, 1 bit, single-cycle strobe for an accepted byte.
REQ-012 SHALL have ports frame_err, parity_err and unknown_cmd, outputs, 1 bit each, single-cycle error strobes.

Function
REQ-013 SHALL synchronise uart_rx through 2 flops before any use; the synchroniser resets to 1.
REQ-014 SHALL generate a x16 oversample tick from a counter of DIV = CLK_FREQ/(BAUD*16), integer-truncated, wrapping DIV-1 -> 0.
REQ-015 SHALL run the FSM IDLE -> START -> DATA -> PAR -> STOP -> IDLE; PAR is skipped when PARITY=0.
REQ-016 IDLE: a synchronised 0 SHALL enter START and restart the tick phase.
REQ-017 START: after 8 ticks, the line SHALL be sampled; 1 = false start -> IDLE with no strobe, 0 = go to DATA.
REQ-018 DATA: 8 bits SHALL be sampled every 16 ticks, LSB first, into a shift register.
REQ-019 PAR: one bit SHALL be sampled after 16 ticks; a mismatch with even/odd parity over the data SHALL latch a pending parity error.
REQ-020 STOP: the line SHALL be sampled after 16 ticks. If 1 and no pending parity error -> accept. If 1 with a pending error -> parity_err pulse. If 0 -> frame_err pulse and enter BRK.
REQ-021 BRK: the FSM SHALL stay in BRK until the synchronised line is 1, then return to IDLE.
REQ-022 Accept SHALL assert rx_valid for 1 cycle, in the cycle after the stop sample; rx_data SHALL update in that same cycle and hold until the next accept.
REQ-023 Decode SHALL be registered, with outputs in the same cycle as rx_valid; letters are case-insensitive.
  - 'r' -> btn_r; 'l' -> btn_l; 'u' -> btn_u; 'd' -> btn_d; 's' -> btn_s.
  - '0'+k, for k < NUM_SW, toggles sw_out[k].
  - 'c' clears all of sw_out to 0.
  - Any other byte -> unknown_cmd.
REQ-024 Errored bytes SHALL produce no rx_valid, no command pulse and no sw change.
REQ-025 At most one of the command pulses and the error strobes SHALL be high in any cycle.
REQ-026 A new start bit SHALL be detected while in IDLE in the cycle after STOP; back-to-back frames SHALL need no idle gap.

Reset
REQ-027 Asserting reset (low) SHALL force all of the following immediately, regardless of clk:
  - FSM to IDLE; tick and bit counters to 0.
  - sw_out = 0; rx_data = 8'h00.
  - All pulse and strobe outputs = 0.
REQ-028 Reset mid-frame SHALL discard the partial byte; after release, reception SHALL resume on the next falling edge.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, the PARITY encodings and the ASCII command constants (r, l, u, d, s, c, '0').
REQ-030 Serial reception (REQ-013 to REQ-022) SHALL be a sub-module uart_rx_os; uart_cmd_ctrl SHALL contain only the decode and sw_out register.

Verification
REQ-031 Defaults, byte 8'h72 sent at 10416 clk/bit -> exactly one rx_valid and one btn_r pulse, with rx_data = 8'h72.
REQ-032 Bytes 8'h30, 8'h31, 8'h32, 8'h30 back-to-back -> sw_out = 5'b00110; then 8'h43 ('C') -> sw_out = 5'b00000.
REQ-033 8'h35 ('5') with NUM_SW=5 -> unknown_cmd pulse, sw_out unchanged; 8'h55 ('U') -> btn_u pulse.
REQ-034 Stop bit driven 0 for 3 bit times, then 8'h64 -> frame_err pulse, no command; the next frame is accepted and gives a btn_d pulse.
REQ-035 PARITY=1, byte 8'h73 sent with parity bit 0 (wrong) -> parity_err pulse, no btn_s; correct parity 1 -> btn_s pulse.
REQ-036 Reset pulsed low mid-DATA of 8'h72 -> all outputs 0 immediately, no btn_r; the following 8'h6C -> btn_l pulse.

Source files
------------

// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared types and constants for the UART command controller.
// Holds the receiver state encoding, the parity modes and the command characters.
package uart_cmd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4,
        ST_BRK   = 3'd5
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam logic [7:0] ASCII_R = 8'h72;
    localparam logic [7:0] ASCII_L = 8'h6C;
    localparam logic [7:0] ASCII_U = 8'h75;
    localparam logic [7:0] ASCII_D = 8'h64;
    localparam logic [7:0] ASCII_S = 8'h73;
    localparam logic [7:0] ASCII_C = 8'h63;
    localparam logic [7:0] ASCII_0 = 8'h30;

    // Folds 'A'..'Z' onto 'a'..'z'; every other byte passes through.
    function automatic logic [7:0] to_lower(input logic [7:0] b);
        if (b >= 8'h41 && b <= 8'h5A) begin
            return b | 8'h20;
        end
        return b;
    endfunction

endpackage

// File: rtl/uart_rx_os.sv
// x16 oversampling UART receiver with optional parity and break handling.
// Produces a combinational accept strobe for the decoder plus registered byte/error strobes.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | line idle, waiting for a synchronised 0
// ST_START | counting 8 ticks to the middle of the start bit
// ST_DATA  | sampling 8 data bits LSB first, one every 16 ticks
// ST_PAR   | sampling the parity bit (only when PARITY != PAR_NONE)
// ST_STOP  | sampling the stop bit, deciding accept / parity / frame
// ST_BRK   | line held low after a framing error, waiting for a 1
module uart_rx_os
    import uart_cmd_ctrl_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int PARITY   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic       accept,
    output logic [7:0] accept_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int DIV   = CLK_FREQ / (BAUD * 16);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic             sync_1, sync_2, rx_s;
    logic [DIV_W-1:0] div_cnt;
    logic             tick, phase_rst;
    rx_state_t        state, state_d;
    logic [3:0]       tick_cnt, tick_cnt_d;
    logic [2:0]       bit_cnt, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_pend, par_pend_d;
    logic             frame_hit, parity_hit;
    logic             exp_par;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= uart_rx;
            sync_2 <= sync_1;
        end
    end

    assign rx_s = sync_2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (phase_rst || div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick    = (div_cnt == DIV_LAST);
    assign exp_par = (PARITY == PAR_ODD) ? ~(^shift_q) : ^shift_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            tick_cnt <= 4'd0;
            bit_cnt  <= 3'd0;
            shift_q  <= 8'h00;
            par_pend <= 1'b0;
        end else begin
            state    <= state_d;
            tick_cnt <= tick_cnt_d;
            bit_cnt  <= bit_cnt_d;
            shift_q  <= shift_d;
            par_pend <= par_pend_d;
        end
    end

    always_comb begin
        state_d    = state;
        tick_cnt_d = tick_cnt;
        bit_cnt_d  = bit_cnt;
        shift_d    = shift_q;
        par_pend_d = par_pend;
        phase_rst  = 1'b0;
        accept     = 1'b0;
        frame_hit  = 1'b0;
        parity_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d    = ST_START;
                    phase_rst  = 1'b1;
                    tick_cnt_d = 4'd0;
                    bit_cnt_d  = 3'd0;
                    par_pend_d = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (tick_cnt == 4'd7) begin
                        tick_cnt_d = 4'd0;
                        state_d    = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    // 4-bit tick count wraps to 0 on the sample tick by itself.
                    tick_cnt_d = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        shift_d   = {rx_s, shift_q[7:1]};
                        bit_cnt_d = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PAR;
                        end
                    end
                end
            end
            ST_PAR: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        par_pend_d = (rx_s != exp_par);
                        state_d    = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        if (rx_s) begin
                            accept     = !par_pend;
                            parity_hit = par_pend;
                            state_d    = ST_IDLE;
                        end else begin
                            frame_hit = 1'b1;
                            state_d   = ST_BRK;
                        end
                    end
                end
            end
            ST_BRK: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign accept_data = shift_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            rx_data    <= 8'h00;
        end else begin
            rx_valid   <= accept;
            frame_err  <= frame_hit;
            parity_err <= parity_hit;
            if (accept) begin
                rx_data <= shift_q;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: receives bytes and decodes them into button pulses and switch toggles.
// Decode is registered on the same edge as the receiver's byte strobe so all outputs line up.
module uart_cmd_ctrl
    import uart_cmd_ctrl_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int NUM_SW   = 5,
    parameter int PARITY   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    output logic [NUM_SW-1:0] sw_out,
    output logic              btn_r,
    output logic              btn_l,
    output logic              btn_u,
    output logic              btn_d,
    output logic              btn_s,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              parity_err,
    output logic              unknown_cmd
);

    logic              accept;
    logic [7:0]        accept_data;
    logic [7:0]        lc;
    logic              cmd_r, cmd_l, cmd_u, cmd_d, cmd_s, cmd_clr, cmd_unk;
    logic [NUM_SW-1:0] sw_tog;

    uart_rx_os #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .PARITY   (PARITY)
    ) u_rx (
        .clk         (clk),
        .reset       (reset),
        .uart_rx     (uart_rx),
        .accept      (accept),
        .accept_data (accept_data),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err),
        .parity_err  (parity_err)
    );

    always_comb begin
        cmd_r   = 1'b0;
        cmd_l   = 1'b0;
        cmd_u   = 1'b0;
        cmd_d   = 1'b0;
        cmd_s   = 1'b0;
        cmd_clr = 1'b0;
        cmd_unk = 1'b0;
        sw_tog  = '0;
        lc      = to_lower(accept_data);
        if (lc == ASCII_R) begin
            cmd_r = 1'b1;
        end else if (lc == ASCII_L) begin
            cmd_l = 1'b1;
        end else if (lc == ASCII_U) begin
            cmd_u = 1'b1;
        end else if (lc == ASCII_D) begin
            cmd_d = 1'b1;
        end else if (lc == ASCII_S) begin
            cmd_s = 1'b1;
        end else if (lc == ASCII_C) begin
            cmd_clr = 1'b1;
        end else begin
            // Digits beyond the implemented switches fall through as unknown.
            cmd_unk = 1'b1;
            for (int k = 0; k < NUM_SW; k++) begin
                if (accept_data == ASCII_0 + 8'(k)) begin
                    sw_tog[k] = 1'b1;
                    cmd_unk   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_r       <= 1'b0;
            btn_l       <= 1'b0;
            btn_u       <= 1'b0;
            btn_d       <= 1'b0;
            btn_s       <= 1'b0;
            unknown_cmd <= 1'b0;
            sw_out      <= '0;
        end else begin
            btn_r       <= accept & cmd_r;
            btn_l       <= accept & cmd_l;
            btn_u       <= accept & cmd_u;
            btn_d       <= accept & cmd_d;
            btn_s       <= accept & cmd_s;
            unknown_cmd <= accept & cmd_unk;
            if (accept) begin
                sw_out <= cmd_clr ? '0 : (sw_out ^ sw_tog);
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: a no-parity and an even-parity instance driven by bit-level frames.
// Expected output events are queued when a frame is sent and popped when the DUT pulses.
module tb_uart_cmd_ctrl;

    localparam int CLK_FREQ = 614_400;
    localparam int BAUD     = 9600;
    localparam int NUM_SW   = 5;
    localparam int BIT_CLKS = 16 * (CLK_FREQ / (BAUD * 16));

    localparam int P_VALID = 8, P_R = 7, P_L = 6, P_U = 5, P_D = 4, P_S = 3, P_UNK = 2, P_FRM = 1, P_PAR = 0;

    typedef struct packed {
        logic [8:0] pulses;
        logic [7:0] data;
        logic [4:0] sw;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic line0 = 1'b1;
    logic line1 = 1'b1;

    logic [4:0] sw0, sw1;
    logic [7:0] rx_data0, rx_data1;
    logic btn_r0, btn_l0, btn_u0, btn_d0, btn_s0, rx_valid0, frame_err0, parity_err0, unknown_cmd0;
    logic btn_r1, btn_l1, btn_u1, btn_d1, btn_s1, rx_valid1, frame_err1, parity_err1, unknown_cmd1;
    logic [8:0] pv0, pv1;

    ev_t exp_q0[$];
    ev_t exp_q1[$];
    logic [4:0] model_sw [2];
    logic [7:0] model_data [2];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_cmd_ctrl #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .NUM_SW(NUM_SW), .PARITY(0)) dut0 (
        .clk(clk), .reset(reset), .uart_rx(line0), .sw_out(sw0),
        .btn_r(btn_r0), .btn_l(btn_l0), .btn_u(btn_u0), .btn_d(btn_d0), .btn_s(btn_s0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .frame_err(frame_err0),
        .parity_err(parity_err0), .unknown_cmd(unknown_cmd0)
    );

    uart_cmd_ctrl #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .NUM_SW(NUM_SW), .PARITY(1)) dut1 (
        .clk(clk), .reset(reset), .uart_rx(line1), .sw_out(sw1),
        .btn_r(btn_r1), .btn_l(btn_l1), .btn_u(btn_u1), .btn_d(btn_d1), .btn_s(btn_s1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .frame_err(frame_err1),
        .parity_err(parity_err1), .unknown_cmd(unknown_cmd1)
    );

    assign pv0 = {rx_valid0, btn_r0, btn_l0, btn_u0, btn_d0, btn_s0, unknown_cmd0, frame_err0, parity_err0};
    assign pv1 = {rx_valid1, btn_r1, btn_l1, btn_u1, btn_d1, btn_s1, unknown_cmd1, frame_err1, parity_err1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int qsize(input int which);
        return (which == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic push_ev(input int which, input ev_t e);
        if (which == 0) exp_q0.push_back(e);
        else            exp_q1.push_back(e);
    endtask

    // Reference decode: what one accepted byte should do to the pulses and switches.
    task automatic expect_byte(input int which, input logic [7:0] b);
        ev_t        e;
        logic [7:0] lc;
        logic [4:0] s;
        int         k;
        lc = (b >= 8'h41 && b <= 8'h5A) ? b + 8'h20 : b;
        s  = model_sw[which];
        e.pulses = '0;
        e.pulses[P_VALID] = 1'b1;
        case (lc)
            8'h72:   e.pulses[P_R] = 1'b1;
            8'h6C:   e.pulses[P_L] = 1'b1;
            8'h75:   e.pulses[P_U] = 1'b1;
            8'h64:   e.pulses[P_D] = 1'b1;
            8'h73:   e.pulses[P_S] = 1'b1;
            8'h63:   s = 5'b0;
            default: begin
                k = int'(b) - 48;
                if (k >= 0 && k < NUM_SW) s[k] = ~s[k];
                else                      e.pulses[P_UNK] = 1'b1;
            end
        endcase
        model_sw[which]   = s;
        model_data[which] = b;
        e.data = b;
        e.sw   = s;
        push_ev(which, e);
    endtask

    task automatic expect_err(input int which, input bit is_frame);
        ev_t e;
        e.pulses = '0;
        if (is_frame) e.pulses[P_FRM] = 1'b1;
        else          e.pulses[P_PAR] = 1'b1;
        e.data = model_data[which];
        e.sw   = model_sw[which];
        push_ev(which, e);
    endtask

    task automatic drive(input int which, input logic v);
        if (which == 0) line0 = v;
        else            line1 = v;
    endtask

    task automatic wait_bits(input int n);
        repeat (n * BIT_CLKS) @(posedge clk);
    endtask

    // par_bit < 0 means no parity bit; stop_low > 0 holds the stop position low that many bit times.
    task automatic send_frame(input int which, input logic [7:0] b, input int par_bit, input int stop_low);
        drive(which, 1'b0);
        wait_bits(1);
        for (int i = 0; i < 8; i++) begin
            drive(which, b[i]);
            wait_bits(1);
        end
        if (par_bit >= 0) begin
            drive(which, par_bit[0]);
            wait_bits(1);
        end
        if (stop_low > 0) begin
            drive(which, 1'b0);
            wait_bits(stop_low);
        end
        drive(which, 1'b1);
        wait_bits(1);
    endtask

    task automatic drain(input int which);
        int t;
        t = 0;
        while (qsize(which) != 0 && t < 400) begin
            @(posedge clk);
            t++;
        end
        chk((which == 0) ? "pending_events0" : "pending_events1", 32'(qsize(which)), 32'd0);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (pv0 != 9'd0) begin
            if (exp_q0.size() == 0) begin
                chk("unexpected_event0", 32'(pv0), 32'd0);
            end else begin
                e = exp_q0.pop_front();
                chk("pulses0", 32'(pv0), 32'(e.pulses));
                chk("rx_data0", 32'(rx_data0), 32'(e.data));
                chk("sw_out0", 32'(sw0), 32'(e.sw));
            end
        end
    end

    always @(negedge clk) begin
        ev_t e;
        if (pv1 != 9'd0) begin
            if (exp_q1.size() == 0) begin
                chk("unexpected_event1", 32'(pv1), 32'd0);
            end else begin
                e = exp_q1.pop_front();
                chk("pulses1", 32'(pv1), 32'(e.pulses));
                chk("rx_data1", 32'(rx_data1), 32'(e.data));
                chk("sw_out1", 32'(sw1), 32'(e.sw));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish before %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] sw_seq [4];
        logic [7:0] abort_b;
        sw_seq = '{8'h30, 8'h31, 8'h32, 8'h30};
        abort_b = 8'h72;
        model_sw[0] = '0;  model_sw[1] = '0;
        model_data[0] = '0; model_data[1] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_pulses", 32'(pv0), 32'd0);
        chk("reset_rx_data", 32'(rx_data0), 32'd0);
        chk("reset_sw_out", 32'(sw0), 32'd0);
        @(negedge clk) reset = 1'b1;
        repeat (5) @(posedge clk);

        expect_byte(0, 8'h72);
        send_frame(0, 8'h72, -1, 0);
        drain(0);
        chk("rx_data_after_r", 32'(rx_data0), 32'h72);

        for (int i = 0; i < 4; i++) begin
            expect_byte(0, sw_seq[i]);
            send_frame(0, sw_seq[i], -1, 0);
        end
        drain(0);
        chk("sw_toggles", 32'(sw0), 32'b00110);

        expect_byte(0, 8'h43);
        send_frame(0, 8'h43, -1, 0);
        drain(0);
        chk("sw_clear", 32'(sw0), 32'b00000);

        expect_byte(0, 8'h34);
        send_frame(0, 8'h34, -1, 0);
        expect_byte(0, 8'h35);
        send_frame(0, 8'h35, -1, 0);
        expect_byte(0, 8'h55);
        send_frame(0, 8'h55, -1, 0);
        drain(0);
        chk("sw_after_digit5", 32'(sw0), 32'b10000);

        // Glitch shorter than half a bit must be rejected as a false start.
        line0 = 1'b0;
        repeat (8) @(posedge clk);
        line0 = 1'b1;
        wait_bits(2);
        drain(0);

        expect_err(0, 1'b1);
        send_frame(0, 8'h64, -1, 3);
        wait_bits(1);
        expect_byte(0, 8'h64);
        send_frame(0, 8'h64, -1, 0);
        drain(0);

        expect_byte(0, 8'h31);
        send_frame(0, 8'h31, -1, 0);
        drain(0);
        chk("sw_before_reset", 32'(sw0), 32'b10010);

        // Abort 8'h72 with a reset pulse in the middle of its data bits.
        line0 = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 2; i++) begin
            line0 = abort_b[i];
            wait_bits(1);
        end
        line0 = abort_b[2];
        repeat (BIT_CLKS / 2) @(posedge clk);
        line0 = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midreset_pulses", 32'(pv0), 32'd0);
        chk("midreset_rx_data", 32'(rx_data0), 32'd0);
        chk("midreset_sw_out", 32'(sw0), 32'd0);
        model_sw[0] = '0;  model_sw[1] = '0;
        model_data[0] = '0; model_data[1] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        wait_bits(1);
        expect_byte(0, 8'h6C);
        send_frame(0, 8'h6C, -1, 0);
        drain(0);
        chk("rx_data_after_reset", 32'(rx_data0), 32'h6C);

        expect_err(1, 1'b0);
        send_frame(1, 8'h73, 0, 0);
        drain(1);
        chk("rx_data_after_parity_err", 32'(rx_data1), 32'h00);
        expect_byte(1, 8'h73);
        send_frame(1, 8'h73, 1, 0);
        drain(1);
        chk("rx_data_parity_ok", 32'(rx_data1), 32'h73);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
